// File: rtl/tl_rom_responder.sv
`default_nettype none
// ============================================================================
// Module   : tl_rom_responder
// Purpose  : TileLink-style Get responder that fronts a synchronous ROM.
//            Each accepted Get issues a one-cycle ROM read. The returned
//            word, the echoed size and the echoed source are written to a
//            small response queue, and responses leave in acceptance order.
// Ports    : clock                  - sole clock, rising edge
//            reset                  - asynchronous, active-low reset
//            auto_in_a_ready/valid  - A channel handshake (Get requests)
//            auto_in_a_bits_size    - log2 of the requested byte count
//            auto_in_a_bits_source  - transaction ID
//            auto_in_a_bits_address - byte address (bits [2:0] ignored)
//            auto_in_d_ready/valid  - D channel handshake (AccessAckData)
//            auto_in_d_bits_*       - echoed size/source and the full word
//            mem_req_valid/addr     - ROM read enable and word index
//            mem_resp_data          - ROM word, one cycle after the read
// Revision : 1.0 - initial release
// ============================================================================
module tl_rom_responder #(
  parameter int DEPTH = 3
) (
  input  logic        clock,
  input  logic        reset,
  output logic        auto_in_a_ready,
  input  logic        auto_in_a_valid,
  input  logic [1:0]  auto_in_a_bits_size,
  input  logic [8:0]  auto_in_a_bits_source,
  input  logic [16:0] auto_in_a_bits_address,
  input  logic        auto_in_d_ready,
  output logic        auto_in_d_valid,
  output logic [1:0]  auto_in_d_bits_size,
  output logic [8:0]  auto_in_d_bits_source,
  output logic [63:0] auto_in_d_bits_data,
  output logic        mem_req_valid,
  output logic [13:0] mem_req_addr,
  input  logic [63:0] mem_resp_data
);

  localparam int c_CNT_W = $clog2(DEPTH + 1);
  localparam int c_PTR_W = $clog2(DEPTH);
  localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_LAST  = c_PTR_W'(DEPTH - 1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);

  logic                 r_out_of_reset;
  logic [c_CNT_W-1:0]   r_count;
  logic [c_CNT_W-1:0]   w_count_nxt;
  logic [c_CNT_W-1:0]   r_occ;
  logic [c_CNT_W-1:0]   w_occ_nxt;
  logic [c_PTR_W-1:0]   r_wptr;
  logic [c_PTR_W-1:0]   r_rptr;
  logic                 r_inflight_valid;
  logic [1:0]           r_inflight_size;
  logic [8:0]           r_inflight_source;
  logic [63:0]          r_q_data   [DEPTH];
  logic [1:0]           r_q_size   [DEPTH];
  logic [8:0]           r_q_source [DEPTH];
  logic                 w_a_fire;
  logic                 w_d_fire;
  logic                 w_enq;
  logic                 w_unused_addr;

  // Sub-word offset is not needed: the full ROM word is always returned.
  assign w_unused_addr = ^auto_in_a_bits_address[2:0];

  // a_ready is purely registered state, so it never depends on d_ready
  // or a_valid in the same cycle. The counter covers the in-flight slot
  // as well as queued entries, which is what keeps the queue from
  // overflowing.
  assign auto_in_a_ready = r_out_of_reset && (r_count < c_DEPTH_CNT);
  assign w_a_fire        = auto_in_a_valid && auto_in_a_ready;
  assign w_d_fire        = auto_in_d_valid && auto_in_d_ready;
  assign w_enq           = r_inflight_valid;

  assign mem_req_valid   = w_a_fire;
  assign mem_req_addr    = auto_in_a_bits_address[16:3];

  assign auto_in_d_valid       = (r_occ != '0);
  assign auto_in_d_bits_size   = r_q_size[r_rptr];
  assign auto_in_d_bits_source = r_q_source[r_rptr];
  assign auto_in_d_bits_data   = r_q_data[r_rptr];

  function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_LAST) ? '0 : p + c_PTR_ONE;
  endfunction

  always_comb begin
    w_count_nxt = r_count;
    if (w_a_fire && !w_d_fire) begin
      w_count_nxt = r_count + c_CNT_ONE;
    end else if (!w_a_fire && w_d_fire) begin
      w_count_nxt = r_count - c_CNT_ONE;
    end
  end

  always_comb begin
    w_occ_nxt = r_occ;
    if (w_enq && !w_d_fire) begin
      w_occ_nxt = r_occ + c_CNT_ONE;
    end else if (!w_enq && w_d_fire) begin
      w_occ_nxt = r_occ - c_CNT_ONE;
    end
  end

  // Control state: cleared asynchronously so any pending responses vanish
  // the moment reset asserts.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_out_of_reset    <= 1'b0;
      r_count           <= '0;
      r_occ             <= '0;
      r_wptr            <= '0;
      r_rptr            <= '0;
      r_inflight_valid  <= 1'b0;
      r_inflight_size   <= '0;
      r_inflight_source <= '0;
    end else begin
      r_out_of_reset   <= 1'b1;
      r_count          <= w_count_nxt;
      r_occ            <= w_occ_nxt;
      r_inflight_valid <= w_a_fire;
      if (w_a_fire) begin
        r_inflight_size   <= auto_in_a_bits_size;
        r_inflight_source <= auto_in_a_bits_source;
      end
      if (w_enq) begin
        r_wptr <= ptr_inc(r_wptr);
      end
      if (w_d_fire) begin
        r_rptr <= ptr_inc(r_rptr);
      end
    end
  end

  // Queue storage carries no reset; occupancy alone says what is valid.
  always_ff @(posedge clock) begin
    if (w_enq) begin
      r_q_data[r_wptr]   <= mem_resp_data;
      r_q_size[r_wptr]   <= r_inflight_size;
      r_q_source[r_wptr] <= r_inflight_source;
    end
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
    !(w_enq && (r_occ == c_DEPTH_CNT)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_tl_rom_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_tl_rom_responder
// Purpose  : Self-checking bench for tl_rom_responder (DEPTH = 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tl_rom_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        a_ready;
  logic        a_valid = 1'b0;
  logic [1:0]  a_size = '0;
  logic [8:0]  a_source = '0;
  logic [16:0] a_address = '0;
  logic        d_ready = 1'b0;
  logic        d_valid;
  logic [1:0]  d_size;
  logic [8:0]  d_source;
  logic [63:0] d_data;
  logic        mem_req_valid;
  logic [13:0] mem_req_addr;
  logic [63:0] mem_resp_data = '0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rx = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [1:0]  size;
    logic [8:0]  source;
    logic [63:0] data;
  } resp_t;

  resp_t exp_q[$];
  int    dcyc[$];
  resp_t mon_e;

  typedef struct {
    logic        av;
    logic [1:0]  sz;
    logic [8:0]  src;
    logic [16:0] addr;
    logic        dr;
    logic        e_ar;
    logic        e_mv;
    logic [13:0] e_ma;
    logic        e_dv;
    logic [1:0]  e_ds;
    logic [8:0]  e_dsrc;
    logic [63:0] e_dd;
  } vec_t;

  vec_t tbl[18];

  tl_rom_responder #(.DEPTH(3)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .auto_in_a_ready        (a_ready),
    .auto_in_a_valid        (a_valid),
    .auto_in_a_bits_size    (a_size),
    .auto_in_a_bits_source  (a_source),
    .auto_in_a_bits_address (a_address),
    .auto_in_d_ready        (d_ready),
    .auto_in_d_valid        (d_valid),
    .auto_in_d_bits_size    (d_size),
    .auto_in_d_bits_source  (d_source),
    .auto_in_d_bits_data    (d_data),
    .mem_req_valid          (mem_req_valid),
    .mem_req_addr           (mem_req_addr),
    .mem_resp_data          (mem_resp_data)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // ROM contents: one fixed word at 0x1E1, an address-derived pattern elsewhere.
  function automatic logic [63:0] rom(input logic [13:0] a);
    if (a == 14'h1E1) return 64'h0123456789ABCDEF;
    return {16'hC0DE, 2'b00, a, 16'h5A5A, 2'b00, a};
  endfunction

  always @(posedge clock) begin
    if (mem_req_valid) mem_resp_data <= rom(mem_req_addr);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: A-fires push the expected response, D-fires pop and compare.
  always @(negedge clock) begin
    if (mon_en && reset) begin
      if (d_valid && d_ready) begin
        rx++;
        dcyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_d: got D beat source %h, expected none", d_source);
        end else begin
          mon_e = exp_q.pop_front();
          chk("d_source", d_source, mon_e.source);
          chk("d_size", d_size, mon_e.size);
          chk("d_data", d_data, mon_e.data);
        end
      end
      if (a_valid && a_ready) begin
        chk("mem_req_valid", mem_req_valid, 1'b1);
        chk("mem_req_addr", mem_req_addr, a_address[16:3]);
        exp_q.push_back('{a_size, a_source, rom(a_address[16:3])});
      end
    end
  end

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    chk("drain_remaining", exp_q.size(), 0);
  endtask

  task automatic get(input logic [1:0] sz, input logic [8:0] src, input logic [16:0] addr);
    @(posedge clock); #1;
    a_valid = 1'b1; a_size = sz; a_source = src; a_address = addr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    int sent;
    int n;

    tbl[0]  = '{1, 3, 9'h1A5, 17'h00F08, 0, 1, 1, 14'h1E1, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 1, 0, 0, 1, 3, 9'h1A5, 64'h0123456789ABCDEF};
    tbl[3]  = '{0, 0, 0, 0, 0, 1, 0, 0, 1, 3, 9'h1A5, 64'h0123456789ABCDEF};
    tbl[4]  = '{0, 0, 0, 0, 1, 1, 0, 0, 1, 3, 9'h1A5, 64'h0123456789ABCDEF};
    tbl[5]  = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    tbl[6]  = '{1, 0, 9'h010, 17'h00010, 0, 1, 1, 14'h002, 0, 0, 0, 0};
    tbl[7]  = '{1, 1, 9'h011, 17'h00018, 0, 1, 1, 14'h003, 0, 0, 0, 0};
    tbl[8]  = '{1, 2, 9'h012, 17'h00027, 0, 1, 1, 14'h004, 1, 0, 9'h010, rom(14'h002)};
    tbl[9]  = '{1, 3, 9'h013, 17'h00028, 0, 0, 0, 0, 1, 0, 9'h010, rom(14'h002)};
    tbl[10] = '{1, 3, 9'h013, 17'h00028, 0, 0, 0, 0, 1, 0, 9'h010, rom(14'h002)};
    tbl[11] = '{1, 3, 9'h013, 17'h00028, 1, 0, 0, 0, 1, 0, 9'h010, rom(14'h002)};
    tbl[12] = '{1, 3, 9'h013, 17'h00028, 0, 1, 1, 14'h005, 1, 1, 9'h011, rom(14'h003)};
    tbl[13] = '{1, 0, 9'h014, 17'h00030, 0, 0, 0, 0, 1, 1, 9'h011, rom(14'h003)};
    tbl[14] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 9'h011, rom(14'h003)};
    tbl[15] = '{0, 0, 0, 0, 1, 1, 0, 0, 1, 2, 9'h012, rom(14'h004)};
    tbl[16] = '{0, 0, 0, 0, 1, 1, 0, 0, 1, 3, 9'h013, rom(14'h005)};
    tbl[17] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};

    // Reset state, with a request presented to show it is ignored.
    a_valid = 1'b1; a_address = 17'h00F08;
    repeat (2) @(negedge clock);
    chk("rst_a_ready", a_ready, 1'b0);
    chk("rst_d_valid", d_valid, 1'b0);
    chk("rst_mem_req_valid", mem_req_valid, 1'b0);
    @(posedge clock); #1;
    a_valid = 1'b0; reset = 1'b1;
    @(negedge clock);
    chk("release_a_ready_same_cycle", a_ready, 1'b0);
    @(negedge clock);
    chk("release_a_ready_next_cycle", a_ready, 1'b1);

    // Single Get and backpressure, cycle by cycle.
    for (int i = 0; i < 18; i++) begin
      @(posedge clock); #1;
      a_valid = tbl[i].av; a_size = tbl[i].sz; a_source = tbl[i].src;
      a_address = tbl[i].addr; d_ready = tbl[i].dr;
      @(negedge clock);
      chk($sformatf("tbl%0d_a_ready", i), a_ready, tbl[i].e_ar);
      chk($sformatf("tbl%0d_mem_req_valid", i), mem_req_valid, tbl[i].e_mv);
      if (tbl[i].e_mv) chk($sformatf("tbl%0d_mem_req_addr", i), mem_req_addr, tbl[i].e_ma);
      chk($sformatf("tbl%0d_d_valid", i), d_valid, tbl[i].e_dv);
      if (tbl[i].e_dv) begin
        chk($sformatf("tbl%0d_d_size", i), d_size, tbl[i].e_ds);
        chk($sformatf("tbl%0d_d_source", i), d_source, tbl[i].e_dsrc);
        chk($sformatf("tbl%0d_d_data", i), d_data, tbl[i].e_dd);
      end
    end

    // Back-to-back: six Gets, one per cycle, with d_ready held high.
    mon_en = 1'b1;
    dcyc.delete();
    first = 0;
    d_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      get(2'(i), 9'h100 + 9'(i), 17'h01000 + 17'(i * 8));
      @(negedge clock);
      chk("b2b_a_ready", a_ready, 1'b1);
      if (i == 0) first = cyc;
    end
    @(posedge clock); #1;
    a_valid = 1'b0;
    wait_drain(20);
    chk("b2b_beats", dcyc.size(), 6);
    for (int k = 0; k < 6 && k < dcyc.size(); k++)
      chk($sformatf("b2b_beat%0d_cycle", k), dcyc[k], first + 2 + k);

    // Pointer wrap under random downstream backpressure.
    void'($urandom(32'hC0FFEE));
    sent = 0; n = 0; rx = 0;
    while ((sent < 10 || exp_q.size() != 0) && n < 300) begin
      @(posedge clock); #1;
      a_valid = (sent < 10);
      a_size = 2'(3 - (sent % 4));
      a_source = 9'h040 + 9'(sent);
      a_address = 17'((sent * 37 + 5) * 8 + 3);
      d_ready = 1'($urandom_range(0, 1));
      @(negedge clock);
      if (a_valid && a_ready) sent++;
      n++;
    end
    @(posedge clock); #1;
    a_valid = 1'b0; d_ready = 1'b0;
    @(negedge clock);
    chk("wrap_sent", sent, 10);
    chk("wrap_received", rx, 10);

    // Reset mid-operation: two queued responses plus one in flight.
    for (int i = 0; i < 3; i++) begin
      get(2'd1, 9'h0A0 + 9'(i), 17'h00200 + 17'(i * 8));
      @(negedge clock);
      chk("midrst_accept", a_ready, 1'b1);
    end
    chk("midrst_pre_d_valid", d_valid, 1'b1);
    @(posedge clock); #1;
    a_valid = 1'b0;
    reset = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_d_valid", d_valid, 1'b0);
    chk("midrst_a_ready", a_ready, 1'b0);
    chk("midrst_mem_req_valid", mem_req_valid, 1'b0);
    @(posedge clock); #1;
    reset = 1'b1;
    d_ready = 1'b1;
    rx = 0;
    @(negedge clock);
    chk("midrst_release_a_ready", a_ready, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("midrst_ready_after", a_ready, 1'b1);
      chk("midrst_no_stale", d_valid, 1'b0);
    end
    get(2'd2, 9'h1FF, 17'h1FFF8);
    @(posedge clock); #1;
    a_valid = 1'b0;
    wait_drain(10);
    chk("midrst_new_rx", rx, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tl_rom_responder.md
TL_ROM_RESPONDER -- requirements
Module: tl_rom_responder

Interface
REQ-001 Parameter: DEPTH, 3, response-queue entries and the maximum number of outstanding Gets (legal range 2..4).
REQ-002 Port: clock  input  1  sole clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset; 0 = in reset.
REQ-004 Port: auto_in_a_ready  output  1  block accepts a Get this cycle.
REQ-005 Port: auto_in_a_valid  input  1  upstream fragmenter presents a Get.
REQ-006 Port: auto_in_a_bits_size  input  2  log2 bytes requested (0..3).
REQ-007 Port: auto_in_a_bits_source  input  9  transaction ID.
REQ-008 Port: auto_in_a_bits_address  input  17  byte address.
REQ-009 Port: auto_in_d_ready  input  1  upstream accepts an AccessAckData.
REQ-010 Port: auto_in_d_valid  output  1  response present.
REQ-011 Port: auto_in_d_bits_size  output  2  echoed request size.
REQ-012 Port: auto_in_d_bits_source  output  9  echoed request source.
REQ-013 Port: auto_in_d_bits_data  output  64  full ROM word.
REQ-014 Port: mem_req_valid  output  1  ROM read enable.
REQ-015 Port: mem_req_addr  output  14  ROM word index.
REQ-016 Port: mem_resp_data  input  64  ROM data, valid exactly one cycle after mem_req_valid.

Function
REQ-017 The block SHALL define A-fire as a_valid & a_ready, and D-fire as d_valid & d_ready.
REQ-018 mem_req_valid SHALL equal A-fire combinationally, and mem_req_addr SHALL equal address[16:3]; address[2:0] SHALL be ignored.
REQ-019 On A-fire in cycle N, size and source SHALL be registered into a one-stage in-flight slot, and mem_resp_data, size and source SHALL be written into the queue at the end of cycle N+1.
REQ-020 d_valid SHALL be 1 whenever the queue is non-empty, with d_bits taken from the head entry; there SHALL be no bypass, so the minimum latency is A-fire in N -> d_valid in N+2.
REQ-021 d_bits_data SHALL be the unmodified 64-bit word; byte-lane selection SHALL be left to the receiver.
REQ-022 A 2-bit-or-wider outstanding counter SHALL track in-flight plus queued entries: next = count + A-fire - D-fire.
REQ-023 a_ready SHALL be 1 iff count < DEPTH and the block is out of reset; it SHALL NOT depend combinationally on d_ready or a_valid.
REQ-024 The queue SHALL never overflow, since the counter includes the in-flight slot; a write to a full queue SHALL be flagged by a simulation-only assertion.
REQ-025 Queue read and write pointers SHALL wrap from DEPTH-1 to 0; writing a non-power-of-2 DEPTH SHALL be supported.
REQ-026 Simultaneous enqueue and dequeue SHALL leave occupancy unchanged and SHALL preserve order.
REQ-027 D responses SHALL be returned strictly in A acceptance order.
REQ-028 While d_valid=1 and d_ready=0, all d_bits SHALL be held stable.
REQ-029 With DEPTH=3 and d_ready held at 1, the block SHALL sustain one A-fire and one D-fire per cycle in steady state.

Reset
REQ-030 While reset=0: a_ready=0, d_valid=0, mem_req_valid=0, count=0, pointers=0, in-flight slot empty; queue data need not be reset.
REQ-031 A registered out-of-reset flag SHALL set on the first rising clock edge after reset deasserts, so a_ready first rises in that following cycle.
REQ-032 Reset asserted mid-transaction SHALL discard all in-flight and queued responses immediately (asynchronously), and no stale response SHALL appear after release.

Verification
REQ-033 Single Get: size=3, source=0x1A5, address=0x00F08; ROM[0x1E1]=0x0123456789ABCDEF -> mem_req_addr=0x1E1 in N; in N+2, d_valid=1, size=3, source=0x1A5, data=0x0123456789ABCDEF.
REQ-034 Back-to-back: 6 Gets on consecutive cycles with d_ready=1 -> a_ready stays 1; 6 responses on consecutive cycles starting 2 cycles after the first; sources in order.
REQ-035 Backpressure: d_ready=0 and a_valid=1 continuous -> exactly 3 A-fires, then a_ready=0; 1 d_ready pulse -> exactly 1 additional A-fire.
REQ-036 Wrap: 10 Gets with random d_ready (seeded) -> all 10 responses in order with correct data; pointers pass through index 2 -> 0 at least 3 times.
REQ-037 Reset mid-op: 2 queued + 1 in-flight, then reset=0 for 1 cycle -> d_valid=0 immediately; after release, a_ready=1 one cycle later and no D beats occur until a new A-fire.
